// File: rtl/raycast_pkg.sv
// -----------------------------------------------------------------------------
// raycast_pkg
// Shared definitions for the raycast front end: layout of the packed
// player-pose word written by software through the PIO bank, field widths,
// the angle-circle size and the sequencer state encoding.
//
// Pose word layout (32 bits):
//   [31:21] pos_x   (POS_W bits)
//   [20:10] pos_y   (POS_W bits)
//   [9:0]   angle   (ANG_W bits, 1024 units = one full turn)
// -----------------------------------------------------------------------------
package raycast_pkg;

  localparam int POS_W    = 11;
  localparam int ANG_W    = 10;
  localparam int COL_W    = 10;
  localparam int ANG_FULL = 1024;

  localparam int PX_LSB  = 21;
  localparam int PY_LSB  = 10;
  localparam int ANG_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [POS_W-1:0] px;
    logic [POS_W-1:0] py;
    logic [ANG_W-1:0] angle;
  } pose_t;

  // Split the raw PIO word into its pose fields.
  function automatic pose_t unpack_pose(input logic [31:0] word);
    pose_t p;
    p.px    = word[PX_LSB +: POS_W];
    p.py    = word[PY_LSB +: POS_W];
    p.angle = word[ANG_LSB +: ANG_W];
    return p;
  endfunction

endpackage

// File: rtl/ray_column_sequencer_if.sv
// -----------------------------------------------------------------------------
// ray_column_sequencer_if
// Valid/ready ray-request channel from the column sequencer to the raycast
// DDA core.
//
// Signals:
//   ray_valid  request present (master -> slave)
//   ray_ready  core accepts the request (slave -> master)
//   ray_col    column index 0..NUM_COLS-1
//   ray_angle  absolute ray angle, mod 1024
//   ray_px     player x position for this frame
//   ray_py     player y position for this frame
//
// Modports: master (sequencer side), slave (raycast core side).
// -----------------------------------------------------------------------------
interface ray_column_sequencer_if;
  import raycast_pkg::*;

  logic             ray_valid;
  logic             ray_ready;
  logic [COL_W-1:0] ray_col;
  logic [ANG_W-1:0] ray_angle;
  logic [POS_W-1:0] ray_px;
  logic [POS_W-1:0] ray_py;

  modport master (
    output ray_valid,
    output ray_col,
    output ray_angle,
    output ray_px,
    output ray_py,
    input  ray_ready
  );

  modport slave (
    input  ray_valid,
    input  ray_col,
    input  ray_angle,
    input  ray_px,
    input  ray_py,
    output ray_ready
  );

endinterface

// File: rtl/ray_angle_accum.sv
// -----------------------------------------------------------------------------
// ray_angle_accum
// Fixed-point ray-angle accumulator. The integer part is one full turn
// (ANG_W bits) so plain binary overflow gives the mod-360 wrap for free; the
// ANG_FRAC fractional bits keep the per-column step error from piling up
// across the sweep.
//
// Parameters:
//   ANG_FRAC  fractional bits of the accumulator
//   HALF_FOV  half the field of view in angle units (left edge offset)
//   ANG_STEP  per-column increment in accumulator LSBs
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   init_i        load the left-edge angle derived from init_angle_i
//   init_angle_i  player heading (centre of the field of view)
//   step_i        advance by one column
//   angle_o       integer part of the accumulator (registered)
// -----------------------------------------------------------------------------
module ray_angle_accum
  import raycast_pkg::*;
#(
  parameter int ANG_FRAC = 8,
  parameter int HALF_FOV = 85,
  parameter int ANG_STEP = 5472
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init_i,
  input  logic [ANG_W-1:0] init_angle_i,
  input  logic             step_i,
  output logic [ANG_W-1:0] angle_o
);

  localparam int ACC_W = ANG_FRAC + ANG_W;

  localparam logic [ACC_W-1:0] STEP_V = ACC_W'(ANG_STEP);
  localparam logic [ANG_W-1:0] HALF_V = ANG_W'(HALF_FOV);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ANG_W-1:0] start_angle;

  // ANG_W-bit subtraction wraps below zero onto the top of the circle.
  assign start_angle = init_angle_i - HALF_V;

  always_comb begin
    acc_d = acc_q;
    if (init_i) begin
      acc_d = ACC_W'(start_angle) << ANG_FRAC;
    end else if (step_i) begin
      acc_d = acc_q + STEP_V;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign angle_o = acc_q[ACC_W-1 -: ANG_W];

endmodule

// File: rtl/ray_column_sequencer.sv
// -----------------------------------------------------------------------------
// ray_column_sequencer
// Turns the software-written player pose into one ray request per screen
// column. On an accepted frame_start the pose is snapshotted, then NUM_COLS
// requests are issued left to right over a valid/ready handshake. The
// snapshot keeps every frame coherent no matter when software rewrites the
// pose word.
//
// Parameters:
//   NUM_COLS   columns per frame (2..1024)
//   FOV_UNITS  field of view in angle units (1024 units = 360 degrees)
//   ANG_FRAC   fractional bits of the angle accumulator
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   player_word  packed pose from the PIO bank (see raycast_pkg)
//   frame_start  single-cycle start-of-frame pulse
//   ray_if       master side of the ray request channel
//   frame_done   one-cycle pulse after the last column is accepted
//   busy         high while a frame is being swept
//   overrun_cnt  saturating count of ignored frame_start pulses
//
// Build option: define RAY_SEQ_OVERRUN_EN to include the overrun counter;
// without it overrun_cnt is tied to zero.
// -----------------------------------------------------------------------------
module ray_column_sequencer
  import raycast_pkg::*;
#(
  parameter int NUM_COLS  = 640,
  parameter int FOV_UNITS = 171,
  parameter int ANG_FRAC  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            player_word,
  input  logic                   frame_start,
  ray_column_sequencer_if.master ray_if,
  output logic                   frame_done,
  output logic                   busy,
  output logic [7:0]             overrun_cnt
);

  localparam int HALF_FOV = FOV_UNITS / 2;
  // Truncated on purpose: the sweep ends marginally short of the right edge
  // rather than past it.
  localparam int ANG_STEP = (FOV_UNITS << ANG_FRAC) / NUM_COLS;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [COL_W-1:0] col_q;
  logic [COL_W-1:0] col_d;
  logic [POS_W-1:0] px_q;
  logic [POS_W-1:0] py_q;
  logic             frame_done_q;
  logic             frame_done_d;
  logic [ANG_W-1:0] ray_angle;

  pose_t pose_in;
  logic  load;       // snapshot pose and restart the sweep
  logic  step;       // advance to the next column
  logic  hs;         // handshake completes this cycle
  logic  last_col;

  assign pose_in  = unpack_pose(player_word);
  assign hs       = (state_q == RUN) && ray_if.ray_ready;
  assign last_col = (col_q == LAST_COL);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    step         = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (last_col) begin
            frame_done_d = 1'b1;
            // A frame_start landing on the final handshake chains straight
            // into the next frame without an IDLE bubble.
            if (frame_start) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            step = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Column counter, pose shadow, frame_done
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d = col_q;
    if (load) begin
      col_d = '0;
    end else if (step) begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      frame_done_q <= frame_done_d;
      if (load) begin
        px_q <= pose_in.px;
        py_q <= pose_in.py;
      end
    end
  end

  ray_angle_accum #(
    .ANG_FRAC (ANG_FRAC),
    .HALF_FOV (HALF_FOV),
    .ANG_STEP (ANG_STEP)
  ) u_accum (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_i       (load),
    .init_angle_i (pose_in.angle),
    .step_i       (step),
    .angle_o      (ray_angle)
  );

  // ---------------------------------------------------------------------------
  // Overrun counter
  // ---------------------------------------------------------------------------
`ifdef RAY_SEQ_OVERRUN_EN
  logic [7:0] ovr_q;
  logic [7:0] ovr_d;
  logic       ovr_evt;

  // Any frame_start seen in RUN except the one chaining off the last handshake.
  assign ovr_evt = frame_start && (state_q == RUN) && !(hs && last_col);

  always_comb begin
    ovr_d = ovr_q;
    if (ovr_evt && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign ray_if.ray_valid = (state_q == RUN);
  assign ray_if.ray_col   = col_q;
  assign ray_if.ray_angle = ray_angle;
  assign ray_if.ray_px    = px_q;
  assign ray_if.ray_py    = py_q;
  assign busy             = (state_q == RUN);
  assign frame_done       = frame_done_q;

endmodule

// File: tb/tb_ray_column_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ray_column_sequencer
// Directed bench for ray_column_sequencer with an 8-column frame,
// FOV 171, ANG_FRAC 8 (step = 43776/8 = 5472 LSBs = 21.375 units).
// Expected ray angles are hand-computed tables:
//   heading 0    -> 939 960 981 1003 0 21 43 64
//   heading 1020 -> 935 956 977 999 1020 17 39 60
// -----------------------------------------------------------------------------
module tb_ray_column_sequencer;
  import raycast_pkg::*;

  localparam int NCOLS = 8;

`ifdef RAY_SEQ_OVERRUN_EN
  localparam int OVR_STEP = 1;
`else
  localparam int OVR_STEP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] player_word = '0;
  logic        frame_start = 1'b0;
  logic        frame_done;
  logic        busy;
  logic [7:0]  overrun_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int tbl_a [NCOLS] = '{939, 960, 981, 1003, 0, 21, 43, 64};
  int tbl_b [NCOLS] = '{935, 956, 977, 999, 1020, 17, 39, 60};

  ray_column_sequencer_if rif ();

  always #5 clk = ~clk;

  ray_column_sequencer #(
    .NUM_COLS  (NCOLS),
    .FOV_UNITS (171),
    .ANG_FRAC  (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .player_word (player_word),
    .frame_start (frame_start),
    .ray_if      (rif),
    .frame_done  (frame_done),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pose_word(input int px, input int py, input int ang);
    logic [31:0] w;
    w = {px[10:0], py[10:0], ang[9:0]};
    return w;
  endfunction

  function automatic int exp_angle(input int sel, input int k);
    return (sel != 0) ? tbl_b[k] : tbl_a[k];
  endfunction

  task automatic start_frame(input logic [31:0] w);
    player_word = w;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Walks one frame from the currently visible column 0. pat[c] is ray_ready
  // for cycle c; poke_at rewrites player_word, fs_at pulses frame_start.
  task automatic run_frame(input logic [15:0] pat, input int sel, input int px, input int py,
                           input int poke_at, input int fs_at, input bit expect_restart);
    int idx;
    idx = 0;
    for (int c = 0; c < 16 && idx < NCOLS; c++) begin
      rif.ray_ready = pat[c];
      frame_start   = (c == fs_at);
      if (c == poke_at) player_word = pose_word(2047, 1, 1020);
      check_eq("valid", 32'(rif.ray_valid), 1);
      check_eq("busy", 32'(busy), 1);
      check_eq("col", 32'(rif.ray_col), idx);
      check_eq("angle", 32'(rif.ray_angle), exp_angle(sel, idx));
      check_eq("px", 32'(rif.ray_px), px);
      check_eq("py", 32'(rif.ray_py), py);
      if (c > 0) check_eq("done_early", 32'(frame_done), 0);
      if (pat[c]) begin
        $display("ray col=%0d angle=%0d px=%0d py=%0d",
                 rif.ray_col, rif.ray_angle, rif.ray_px, rif.ray_py);
      end
      tick();
      frame_start = 1'b0;
      if (pat[c]) idx++;
    end
    rif.ray_ready = 1'b1;
    check_eq("frame_len", idx, NCOLS);
    check_eq("frame_done", 32'(frame_done), 1);
    check_eq("valid_after", 32'(rif.ray_valid), 32'(expect_restart));
    if (expect_restart) check_eq("restart_col", 32'(rif.ray_col), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rif.ray_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    check_eq("rst_valid", 32'(rif.ray_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(frame_done), 0);
    check_eq("rst_col", 32'(rif.ray_col), 0);
    check_eq("rst_angle", 32'(rif.ray_angle), 0);
    check_eq("rst_px", 32'(rif.ray_px), 0);
    check_eq("rst_ovr", 32'(overrun_cnt), 0);

    reset_n = 1'b1;
    tick();
    check_eq("idle_valid", 32'(rif.ray_valid), 0);

    // Basic sweep, heading 0, ready always high
    start_frame(pose_word(100, 200, 0));
    run_frame(16'hFFFF, 0, 100, 200, -1, -1, 1'b0);
    tick();
    check_eq("done_pulse_end", 32'(frame_done), 0);
    check_eq("idle_busy", 32'(busy), 0);

    // Backpressure: ready 1-0-0-1...
    start_frame(pose_word(100, 200, 0));
    run_frame(16'hFFF9, 0, 100, 200, -1, -1, 1'b0);
    tick();

    // Pose rewritten mid-frame has no effect on the running frame
    start_frame(pose_word(100, 200, 0));
    run_frame(16'hFFFF, 0, 100, 200, 3, -1, 1'b0);
    tick();

    // Next frame picks up the new pose: heading 1020 wraps through 0
    start_frame(pose_word(2047, 1, 1020));
    run_frame(16'hFFFF, 1, 2047, 1, -1, -1, 1'b0);
    tick();

    // frame_start mid-frame is ignored
    start_frame(pose_word(100, 200, 0));
    run_frame(16'hFFFF, 0, 100, 200, -1, 3, 1'b0);
    check_eq("ovr_mid", 32'(overrun_cnt), OVR_STEP);
    tick();

    // frame_start on the last handshake chains a new frame with the new pose
    start_frame(pose_word(100, 200, 0));
    run_frame(16'hFFFF, 0, 100, 200, 7, 7, 1'b1);
    check_eq("ovr_chain", 32'(overrun_cnt), OVR_STEP);
    check_eq("chain_busy", 32'(busy), 1);
    run_frame(16'hFFFF, 1, 2047, 1, -1, -1, 1'b0);
    tick();

    // Reset in the middle of a frame
    start_frame(pose_word(100, 200, 0));
    repeat (3) tick();
    check_eq("pre_rst_col", 32'(rif.ray_col), 3);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(rif.ray_valid), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_col", 32'(rif.ray_col), 0);
    tick();
    tick();
    check_eq("midrst_done", 32'(frame_done), 0);
    reset_n = 1'b1;
    tick();
    check_eq("post_rst_done", 32'(frame_done), 0);
    check_eq("post_rst_valid", 32'(rif.ray_valid), 0);
    start_frame(pose_word(100, 200, 0));
    run_frame(16'hFFFF, 0, 100, 200, -1, -1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ray_column_sequencer.md
# ray_column_sequencer

Consumes the packed player-pose word driven by the player PIO output register and turns it into one ray request per screen column for the raycast DDA engine. On each frame start it snapshots the pose word, then issues NUM_COLS requests (column index, ray angle, player position) over a valid/ready handshake, sweeping the field of view left to right. It sits between the Avalon PIO bank (software-written pose) and the raycast core, so the pose is frame-coherent regardless of when software writes it.

## Interface
- NUM_COLS, 640, columns per frame (2..1024)
- FOV_UNITS, 171, field of view in angle units (1024 units = 360°)
- ANG_FRAC, 8, fractional bits of the angle accumulator
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- player_word  in  32  pose from PIO out_port: [31:21] pos_x, [20:10] pos_y, [9:0] angle
- frame_start  in  1  single-cycle pulse at start of frame (from VGA vsync edge)
- ray_valid  out  1  request present
- ray_ready  in  1  raycast core accepts request
- ray_col  out  10  column index 0..NUM_COLS-1
- ray_angle  out  10  absolute ray angle, mod 1024
- ray_px  out  11  snapshotted pos_x
- ray_py  out  11  snapshotted pos_y
- frame_done  out  1  one-cycle pulse after last column accepted
- busy  out  1  high in RUN
- overrun_cnt  out  8  frame_start pulses dropped (see Configuration)

## Operation
- States: IDLE, RUN. Reset -> IDLE; all outputs 0.
- IDLE: on frame_start, latch player_word into shadow (px, py, angle); col <= 0; acc <= ((angle - FOV_UNITS/2) mod 1024) << ANG_FRAC; -> RUN.
- RUN: ray_valid=1, ray_angle = acc[ANG_FRAC+9:ANG_FRAC]. On ray_valid && ray_ready: col++, acc += ANG_STEP, where localparam ANG_STEP = (FOV_UNITS << ANG_FRAC) / NUM_COLS (truncated). Accumulator width ANG_FRAC+10; overflow wraps (mod 360°).
- Last column (col == NUM_COLS-1) accepted: frame_done pulses next cycle; -> IDLE, unless frame_start is high in that same cycle, in which case it is accepted as the next frame (re-latch, re-init, stay RUN).
- frame_start in RUN any other cycle: ignored; counted as overrun when enabled. Current frame continues with its original snapshot.
- player_word changes mid-frame have no effect until the next accepted frame_start.
- Reset asserted mid-frame: immediate return to IDLE, ray_valid=0, no frame_done.

## Timing
- All outputs registered.
- frame_start at cycle N -> ray_valid=1, ray_col=0 at N+1.
- ray_ready held high: one request per cycle; NUM_COLS requests occupy N+1..N+NUM_COLS; frame_done at N+NUM_COLS+1.
- While ray_valid && !ray_ready: ray_col, ray_angle, ray_px, ray_py held stable.
- ray_valid never drops in RUN until last handshake.

## Configuration
- RAY_SEQ_OVERRUN_EN defined: overrun_cnt increments (saturating at 255) on each ignored frame_start; cleared only by reset.
- Undefined: counter logic absent, overrun_cnt tied to 0.

## Structure
- Shared package raycast_pkg: pose field positions/widths (POS_W=11, ANG_W=10), ANG_FULL=1024, state enum.
- One sub-module natural: ray_angle_accum (init/step/wrap fixed-point accumulator).
- Top holds FSM, column counter, pose shadow, handshake.

## Test plan
- NUM_COLS=8, FOV=171, ANG_FRAC=8, angle=0, ready high, frame_start -> cols 0..7 on 8 consecutive cycles, angles 939, 960, ...; frame_done one cycle after col 7.
- Angle=1020 -> col 0 angle 935, col 7 angle 60 (wrap); px/py equal snapshot.
- Ready toggled 1-0-0-1 during frame -> outputs held during low cycles, no column skipped or repeated, 8 handshakes total.
- player_word rewritten mid-frame -> ray_px/ray_py/angles unchanged until next frame_start.
- frame_start mid-frame (macro on) -> ignored, overrun_cnt=1; frame_start coincident with last handshake -> new frame starts, overrun_cnt unchanged, no IDLE cycle.
- reset_n low at col 3 -> ray_valid=0, busy=0, no frame_done; next frame_start restarts at col 0.
